// File: rtl/cordiv_operand_sng_pkg.sv
// Shared types and elaboration-time helpers for the CORDIV operand stream generator.
// sng_len follows CORDIV_SNG_LFSR_EN: 2^bw-1 with the LFSR, 2^bw with the counter.
package cordiv_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  // Fibonacci feedback masks (shift-left, feedback into bit 0), maximal length for 4..16 bits
  function automatic logic [15:0] lfsr_taps(input int bw);
    case (bw)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int sng_len(input int bw);
`ifdef CORDIV_SNG_LFSR_EN
    return (1 << bw) - 1;
`else
    return 1 << bw;
`endif
  endfunction

endpackage

// File: rtl/cordiv_operand_sng_if.sv
// Operand-in / bitstream-out handshake bundle of the CORDIV stream generator.
// slave is the generator side, master the producer/consumer environment side.
interface cordiv_operand_sng_if #(
  parameter int BW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] dividend_bin;
  logic [BW-1:0] divisor_bin;
  logic          out_ready;
  logic          out_valid;
  logic          dividend;
  logic          divisor;
  logic          out_last;

  modport slave (
    input  in_valid, dividend_bin, divisor_bin, out_ready,
    output in_ready, out_valid, dividend, divisor, out_last
  );

  modport master (
    output in_valid, dividend_bin, divisor_bin, out_ready,
    input  in_ready, out_valid, dividend, divisor, out_last
  );
endinterface

// File: rtl/cordiv_operand_sng_rng.sv
// Shared random source: LFSR (rnd = lfsr-1) with CORDIV_SNG_LFSR_EN, plain up-counter otherwise.
// rnd is the value the next loaded stream bit compares against (initial value while init is high).
module cordiv_rng
  import cordiv_pkg::*;
#(
  parameter int            BW   = 8,
  parameter logic [BW-1:0] SEED = BW'(1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          advance,
  output logic [BW-1:0] rnd
);

`ifdef CORDIV_SNG_LFSR_EN
  localparam logic [15:0]   TAPS_ALL = lfsr_taps(BW);
  localparam logic [BW-1:0] TAPS     = TAPS_ALL[BW-1:0];

  logic [BW-1:0] lfsr;
  logic [BW-1:0] lfsr_step;
  logic [BW-1:0] lfsr_nxt;

  assign lfsr_step = {lfsr[BW-2:0], ^(lfsr & TAPS)};
  assign lfsr_nxt  = init ? SEED : lfsr_step;
  // LFSR never holds zero, so subtracting one maps it onto 0..2^BW-2
  assign rnd       = lfsr_nxt - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (init || advance) begin
      lfsr <= lfsr_nxt;
    end
  end
`else
  logic [BW-1:0] cnt;
  logic [BW-1:0] cnt_nxt;
  logic          unused_seed;

  assign unused_seed = ^SEED;
  assign cnt_nxt     = init ? '0 : cnt + 1'b1;
  assign rnd         = cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (init || advance) begin
      cnt <= cnt_nxt;
    end
  end
`endif

endmodule

// File: rtl/cordiv_operand_sng.sv
// CORDIV transmit side: turns one (dividend, divisor) pair into two correlated unipolar bitstreams.
// Build option CORDIV_SNG_LFSR_EN selects the LFSR random source instead of the thermometer counter.
module cordiv_operand_sng
  import cordiv_pkg::*;
#(
  parameter int            BW   = 8,
  parameter logic [BW-1:0] SEED = BW'(1)
) (
  input logic                 clk,
  input logic                 rst_n,
  cordiv_operand_sng_if.slave bus
);

  localparam int            LEN  = sng_len(BW);
  localparam logic [BW-1:0] LAST = BW'(LEN - 1);

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] div_r;
  logic [BW-1:0] dvs_r;
  logic [BW-1:0] cnt;
  logic [BW-1:0] cnt_inc;
  logic [BW-1:0] clamp;
  logic [BW-1:0] rnd;
  logic          valid_r;
  logic          dividend_r;
  logic          divisor_r;
  logic          last_r;
  logic          in_ready;
  logic          accept;
  logic          xfer;

  assign in_ready = (state == IDLE) || ((state == RUN) && last_r && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = valid_r && bus.out_ready;
  assign cnt_inc  = cnt + 1'b1;
  // clamping keeps the quotient at or below one
  assign clamp    = (bus.dividend_bin < bus.divisor_bin) ? bus.dividend_bin : bus.divisor_bin;

  cordiv_rng #(
    .BW  (BW),
    .SEED(SEED)
  ) u_rng (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (accept),
    .advance(xfer),
    .rnd    (rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (xfer && last_r) state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r      <= '0;
      dvs_r      <= '0;
      cnt        <= '0;
      valid_r    <= 1'b0;
      dividend_r <= 1'b0;
      divisor_r  <= 1'b0;
      last_r     <= 1'b0;
    end else if (accept) begin
      div_r      <= clamp;
      dvs_r      <= bus.divisor_bin;
      cnt        <= '0;
      valid_r    <= 1'b1;
      dividend_r <= clamp > rnd;
      divisor_r  <= bus.divisor_bin > rnd;
      last_r     <= (LAST == '0);
    end else if (xfer) begin
      if (last_r) begin
        valid_r    <= 1'b0;
        dividend_r <= 1'b0;
        divisor_r  <= 1'b0;
        last_r     <= 1'b0;
      end else begin
        cnt        <= cnt_inc;
        dividend_r <= div_r > rnd;
        divisor_r  <= dvs_r > rnd;
        last_r     <= (cnt_inc == LAST);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_r;
  assign bus.dividend  = dividend_r;
  assign bus.divisor   = divisor_r;
  assign bus.out_last  = last_r;

endmodule
